// File: rtl/idct8_stream.sv
// idct8_stream: serial 1-D 8-point inverse DCT.
// Eight coefficients X[0..7] enter one per beat. Four even and four odd MACs
// build the partial sums. A double-buffered output stage then emits
// x[0..7] through a sum/difference butterfly. The butterfly output is
// rounded, scaled and saturated to OUT_WIDTH bits.
module idct8_stream #(
   parameter int DATA_WIDTH = 10,
   parameter int COEF_WIDTH = 13,
   parameter int COEF_FRAC  = 12,
   parameter int OUT_WIDTH  = 9
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic signed [OUT_WIDTH-1:0]  out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last
);

   localparam int ACC = DATA_WIDTH + COEF_WIDTH + 3;
   localparam int SW  = ACC + 1;
   localparam logic signed [SW-1:0] RND  = SW'(2 ** (COEF_FRAC - 1));
   localparam logic signed [SW-1:0] MAXV = SW'(2 ** (OUT_WIDTH - 1) - 1);
   localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (OUT_WIDTH - 1)));

   logic [2:0]            kIdx;      // index of the next coefficient to accept
   logic [2:0]            nIdx;      // index of the sample being presented
   logic                  bufFull;
   logic signed [ACC-1:0] accE [4];
   logic signed [ACC-1:0] accO [4];
   logic signed [ACC-1:0] bufE [4];
   logic signed [ACC-1:0] bufO [4];
   logic signed [ACC-1:0] prod [4];
   logic                  inAccept;
   logic                  outXfer;
   logic [1:0]            pair;
   logic signed [SW-1:0]  sumV;
   logic signed [SW-1:0]  scaled;

   // Cosine ROM entry M[n][k] = round(2^12 * C(k)/2 * cos((2n+1)k*pi/16)).
   // The angle index (2n+1)k is folded mod 32 into the first quadrant.
   // The sign is tracked while folding.
   function automatic logic signed [COEF_WIDTH-1:0] romCoef(input logic [1:0] n,
                                                            input logic [2:0] k);
      logic [4:0] m;
      logic       neg;
      int         mag;
      m   = 5'({n, 1'b1}) * 5'(k);
      neg = 1'b0;
      if (m > 5'd16) m = 5'd0 - m;
      if (m > 5'd8) begin
         neg = 1'b1;
         m   = 5'd16 - m;
      end
      case (m)
         5'd1:    mag = 2009;
         5'd2:    mag = 1892;
         5'd3:    mag = 1703;
         5'd4:    mag = 1448;
         5'd5:    mag = 1138;
         5'd6:    mag = 784;
         5'd7:    mag = 400;
         default: mag = 0;
      endcase
      if (k == 3'd0) mag = 1448;
      return COEF_WIDTH'(neg ? -mag : mag);
   endfunction

   // Handshake rules:
   // - Input side: a beat is taken when in_valid & in_ready.
   // - Output side: a sample moves when out_valid & out_ready.
   // - While out_valid is high and out_ready is low, out_data, out_valid and
   //   out_last hold their values.
   // - Beat 7 can only load the output buffer in two cases: the buffer is
   //   empty, or x7 of the previous block leaves in the same cycle.
   assign inAccept  = in_valid & in_ready;
   assign outXfer   = out_valid & out_ready;
   assign out_valid = bufFull;
   assign out_last  = bufFull & (nIdx == 3'd7);
   assign in_ready  = (kIdx != 3'd7) | ~bufFull | (outXfer & out_last);

   // Products of the current coefficient with the four ROM rows for this k
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         prod[n] = ACC'(romCoef(2'(n), kIdx)) * ACC'(in_data);
      end
   end

   // Beat/sample counters and buffer occupancy; a block load wins over a drain
   always_ff @(posedge clk) begin
      if (rst) begin
         kIdx    <= 3'd0;
         nIdx    <= 3'd0;
         bufFull <= 1'b0;
      end else begin
         if (inAccept) kIdx <= kIdx + 3'd1;
         if (inAccept && kIdx == 3'd7) begin
            bufFull <= 1'b1;
            nIdx    <= 3'd0;
         end else if (outXfer) begin
            nIdx <= nIdx + 3'd1;
            if (out_last) bufFull <= 1'b0;
         end
      end
   end

   // Even/odd MAC accumulation; the block's last beat also snapshots the sums
   always_ff @(posedge clk) begin
      if (inAccept) begin
         for (int n = 0; n < 4; n++) begin
            if (!kIdx[0]) accE[n] <= (kIdx == 3'd0) ? prod[n] : accE[n] + prod[n];
            else          accO[n] <= (kIdx == 3'd1) ? prod[n] : accO[n] + prod[n];
         end
         if (kIdx == 3'd7) begin
            for (int n = 0; n < 4; n++) begin
               bufE[n] <= accE[n];
               bufO[n] <= accO[n] + prod[n];
            end
         end
      end
   end

   // Output butterfly: x[n] = e+o for n<4, x[7-n] = e-o; round, shift, saturate
   always_comb begin
      pair     = nIdx[2] ? ~nIdx[1:0] : nIdx[1:0];
      sumV     = nIdx[2] ? SW'(bufE[pair]) - SW'(bufO[pair])
                         : SW'(bufE[pair]) + SW'(bufO[pair]);
      scaled   = (sumV + RND) >>> COEF_FRAC;
      out_data = '0;
      if (bufFull) begin
         if (scaled > MAXV)      out_data = MAXV[OUT_WIDTH-1:0];
         else if (scaled < MINV) out_data = MINV[OUT_WIDTH-1:0];
         else                    out_data = scaled[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_idct8_stream.sv
// Bench for idct8_stream: directed cases with known sample values, and random
// blocks checked against a floating-point cosine reference. A driver issues
// beats and queues the expected samples. A monitor pops the queue on every
// output transfer and also checks that held outputs stay stable.
module tb_idct8_stream;

   localparam int DW = 10;
   localparam int CW = 13;
   localparam int CF = 12;
   localparam int OW = 9;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic signed [DW-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [OW-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;

   int checks    = 0;
   int failures  = 0;
   int cycle     = 0;
   int readyMode = 0;
   int outPos    = 0;
   int stallCnt  = 0;
   int xferCnt   = 0;
   int firstXfer = 0;
   int lastXfer  = 0;
   logic signed [OW-1:0] expQ[$];

   idct8_stream #(
      .DATA_WIDTH(DW), .COEF_WIDTH(CW), .COEF_FRAC(CF), .OUT_WIDTH(OW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cycle);
      end
   endtask

   // Reference model: direct 8x8 IDCT sum with ROM constants rounded from real cosines
   function automatic int modelOut(input int xs[8], input int n);
      longint acc = 0;
      real    ck;
      int     m;
      for (int k = 0; k < 8; k++) begin
         ck  = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
         m   = int'((2.0 ** CF) * ck / 2.0 * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0));
         acc += longint'(m) * longint'(xs[k]);
      end
      acc = (acc + longint'(2 ** (CF - 1))) >>> CF;
      if (acc > longint'(2 ** (OW - 1) - 1)) return 2 ** (OW - 1) - 1;
      if (acc < -longint'(2 ** (OW - 1)))    return -(2 ** (OW - 1));
      return int'(acc);
   endfunction

   task automatic pushModel(input int xs[8]);
      for (int n = 0; n < 8; n++) expQ.push_back(OW'(modelOut(xs, n)));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one beat until accepted; in_ready is judged at the falling edge
   task automatic sendBeat(input int x);
      int waitCnt = 0;
      in_valid = 1'b1;
      in_data  = DW'(x);
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waitCnt++;
         if (waitCnt > 300) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: actual=stalled %0d cycles required=accept", waitCnt);
            break;
         end
      end
      stallCnt += waitCnt;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic sendBlock(input int xs[8], input int gapPct);
      pushModel(xs);
      for (int k = 0; k < 8; k++) begin
         if (gapPct > 0 && $urandom_range(0, 99) < gapPct) idle($urandom_range(1, 3));
         sendBeat(xs[k]);
      end
   endtask

   task automatic waitDrain();
      int t = 0;
      while (expQ.size() != 0 && t < 1000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain_pending", expQ.size(), 0);
      expQ.delete();
   endtask

   // Sink: out_ready pattern changes just after the rising edge
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops expected samples on each transfer, checks hold-while-stalled
   initial begin
      logic                 prevStall;
      logic signed [OW-1:0] prevData;
      logic                 prevLast;
      logic signed [OW-1:0] e;
      prevStall = 1'b0;
      prevData  = '0;
      prevLast  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevStall = 1'b0;
            outPos    = 0;
            continue;
         end
         if (prevStall) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), int'(prevData));
            check("hold_last", int'(out_last), int'(prevLast));
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: actual=%0d required=no output", out_data);
            end else begin
               e = expQ.pop_front();
               check($sformatf("sample_x%0d", outPos), int'(out_data), int'(e));
               check($sformatf("last_x%0d", outPos), int'(out_last), (outPos == 7) ? 1 : 0);
            end
            outPos = (outPos + 1) % 8;
            if (xferCnt == 0) firstXfer = cycle;
            lastXfer = cycle;
            xferCnt++;
         end
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
         prevLast  = out_last;
      end
   end

   // Watchdog
   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: actual=time limit reached required=normal completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Main sequence
   initial begin
      int xs[8];
      int s0;
      in_valid = 1'b0;
      in_data  = '0;

      // Reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_out_data", int'(out_data), 0);

      // DC block: eight 23s; x0 valid one cycle after the last accept
      xs = '{64, 0, 0, 0, 0, 0, 0, 0};
      for (int n = 0; n < 8; n++) expQ.push_back(OW'(23));
      for (int k = 0; k < 7; k++) sendBeat(xs[k]);
      check("dc_no_early_valid", int'(out_valid), 0);
      sendBeat(xs[7]);
      check("dc_latency_valid", int'(out_valid), 1);
      waitDrain();

      // Single X1 coefficient: x0=49, x7=-49
      xs = '{0, 100, 0, 0, 0, 0, 0, 0};
      expQ.push_back(OW'(49));
      for (int n = 1; n < 7; n++) expQ.push_back(OW'(modelOut(xs, n)));
      expQ.push_back(OW'(-49));
      for (int k = 0; k < 8; k++) sendBeat(xs[k]);
      waitDrain();

      // Saturation, positive then negative
      xs = '{511, 0, 511, 0, 511, 0, 511, 0};
      expQ.push_back(OW'(255));
      for (int n = 1; n < 7; n++) expQ.push_back(OW'(modelOut(xs, n)));
      expQ.push_back(OW'(255));
      for (int k = 0; k < 8; k++) sendBeat(xs[k]);
      waitDrain();
      xs = '{-511, 0, -511, 0, -511, 0, -511, 0};
      expQ.push_back(OW'(-256));
      for (int n = 1; n < 7; n++) expQ.push_back(OW'(modelOut(xs, n)));
      expQ.push_back(OW'(-256));
      for (int k = 0; k < 8; k++) sendBeat(xs[k]);
      waitDrain();

      // Backpressure: back-to-back DC blocks with out_ready toggling
      readyMode = 1;
      stallCnt  = 0;
      for (int n = 0; n < 8; n++) expQ.push_back(OW'(23));
      for (int n = 0; n < 8; n++) expQ.push_back(OW'(-23));
      sendBeat(64);
      for (int k = 1; k < 8; k++) sendBeat(0);
      sendBeat(-64);
      for (int k = 1; k < 7; k++) sendBeat(0);
      check("bp_early_beats_no_stall", stallCnt, 0);
      s0 = stallCnt;
      sendBeat(0);
      check("bp_k7_stalled", (stallCnt > s0) ? 1 : 0, 1);
      waitDrain();
      readyMode = 0;
      idle(2);

      // Streaming: 4 random blocks, no gaps, always ready
      stallCnt = 0;
      xferCnt  = 0;
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 8; k++) xs[k] = int'($urandom_range(0, 1023)) - 512;
         sendBlock(xs, 0);
      end
      waitDrain();
      check("stream_no_stall", stallCnt, 0);
      check("stream_xfer_count", xferCnt, 32);
      check("stream_one_per_cycle", lastXfer - firstXfer, 31);

      // Random blocks with input gaps and random backpressure
      readyMode = 2;
      for (int b = 0; b < 6; b++) begin
         for (int k = 0; k < 8; k++) xs[k] = int'($urandom_range(0, 1023)) - 512;
         sendBlock(xs, 30);
      end
      waitDrain();
      readyMode = 0;
      idle(2);

      // Reset mid-block: aborted beats leave no residue
      for (int k = 0; k < 5; k++) sendBeat(int'($urandom_range(0, 1023)) - 512);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      for (int n = 0; n < 8; n++) expQ.push_back(OW'(23));
      sendBeat(64);
      for (int k = 1; k < 8; k++) sendBeat(0);
      waitDrain();
      idle(20);
      check("final_out_valid", int'(out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
